// File: rtl/stdout_uart_tx.sv
// Processor stdout byte sink: edge-captures bytes into a circular FIFO and
// serialises them as 8N1 UART frames on a registered tx line.
module stdout_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  stdout,
  input  logic                        stdout_en,
  output logic                        tx,
  output logic                        cpu_en,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [1:0]                  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HIGH = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Handshake: a byte is offered by a 0->1 transition of stdout_en (valid);
  // cpu_en is the ready/backpressure, dropping while the FIFO is nearly full.
  // An offer ignoring cpu_en into a full FIFO is dropped and sets overflow.

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q;
  logic          arm_q, arm_d;
  logic          ovf_q, ovf_d;
  logic          cpu_en_q, cpu_en_d;
  logic          tx_q, tx_d;
  logic          line_busy_q;
  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;

  logic capture;
  logic pop;
  logic push;
  logic full;
  logic bit_end;

  // Capture and FIFO bookkeeping
  always_comb begin
    capture  = stdout_en && !en_q && arm_q;
    full     = (count_q == CNT_FULL);
    pop      = (state_q == S_IDLE) && (count_q != '0);
    push     = capture && (!full || pop);
    arm_d    = arm_q || !stdout_en;
    ovf_d    = ovf_q || (capture && full && !pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    cpu_en_d = (count_q < CNT_HIGH);
  end

  // TX FSM next-state and bit timing
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    bit_end   = (bit_cnt_q == BIT_LAST);
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The line level is a registered function of the current state, so tx
  // trails the FSM by one cycle and no input reaches it combinationally.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      en_q        <= 1'b0;
      arm_q       <= !stdout_en;
      ovf_q       <= 1'b0;
      cpu_en_q    <= 1'b1;
      tx_q        <= 1'b1;
      line_busy_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      en_q        <= stdout_en;
      arm_q       <= arm_d;
      ovf_q       <= ovf_d;
      cpu_en_q    <= cpu_en_d;
      tx_q        <= tx_d;
      line_busy_q <= (state_q != S_IDLE);
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= stdout;
    end
  end

  assign tx          = tx_q;
  assign cpu_en      = cpu_en_q;
  assign overflow    = ovf_q;
  assign fifo_count  = count_q;
  assign busy        = (count_q != '0) || (state_q != S_IDLE) || line_busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: directed bytes feed an expected queue; a line
// monitor decodes every 8N1 frame on tx and checks it against that queue.
module tb_stdout_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] stdout = 8'h00;
  logic       stdout_en = 1'b0;
  logic       tx;
  logic       cpu_en;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_seen = 0;
  bit mon_active = 1'b0;
  logic [7:0] exp_q[$];
  int start_q[$];

  stdout_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stdout     (stdout),
    .stdout_en  (stdout_en),
    .tx         (tx),
    .cpu_en     (cpu_en),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required earlier end", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one rising edge of stdout_en; n_cap is the capturing clock edge.
  task automatic send(input logic [7:0] b, input int hold, input bit keep, output int n_cap);
    @(posedge clk);
    #1;
    stdout    = b;
    stdout_en = 1'b1;
    n_cap     = cyc + 1;
    if (keep) exp_q.push_back(b);
    repeat (hold) @(posedge clk);
    #1 stdout_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while ((busy || mon_active) && t < limit) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_timeout", {31'd0, t >= limit}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu_en(input int limit);
    int t;
    t = 0;
    while (!cpu_en && t < limit) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("cpu_en_wait", {31'd0, t < limit}, 32'd1);
  endtask

  function automatic int start_at(input int i);
    return (i < start_q.size()) ? start_q[i] : -1;
  endfunction

  // scoreboard monitor: samples tx on the falling edge, CPB samples per bit
  initial begin : monitor
    int idx;
    int p;
    bit fbad;
    logic [7:0] bits;
    logic [7:0] e;
    idx  = 0;
    fbad = 1'b0;
    bits = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          idx  = 1;
          fbad = 1'b0;
          bits = 8'h00;
          start_q.push_back(cyc);
        end
      end else begin
        p = idx / CPB;
        if (p == 0) begin
          if (tx !== 1'b0) fbad = 1'b1;
        end else if (p <= 8) begin
          if (idx % CPB == 0) bits[p-1] = tx;
          else if (tx !== bits[p-1]) fbad = 1'b1;
        end else if (tx !== 1'b1) begin
          fbad = 1'b1;
        end
        idx++;
        if (idx == FLEN) begin
          mon_active = 1'b0;
          frames_seen++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got byte 0x%0h framing_err=%0d required no frame", bits, fbad);
          end else begin
            e = exp_q.pop_front();
            chk("frame", {23'd0, fbad, bits}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int n2;
    int s;
    int f0;

    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // single byte, latency and one frame only
    start_q.delete();
    f0 = frames_seen;
    send(8'h48, 2, 1'b1, n);
    wait_idle(200);
    chk("single_frames", frames_seen - f0, 32'd1);
    chk("single_latency", start_at(0), n + 2);
    chk("single_busy", {31'd0, busy}, 32'd0);

    // held enable captures once
    f0 = frames_seen;
    send(8'hC3, 20, 1'b1, n);
    wait_idle(300);
    chk("held_frames", frames_seen - f0, 32'd1);

    // burst: contiguous frames, 1-cycle IDLE dwell between them
    start_q.delete();
    send(8'h41, 1, 1'b1, n);
    @(posedge clk);
    send(8'h42, 1, 1'b1, n);
    @(posedge clk);
    send(8'h43, 1, 1'b1, n);
    wait_idle(400);
    chk("burst_frames", start_q.size(), 32'd3);
    chk("burst_gap1", start_at(1) - start_at(0), FLEN + 1);
    chk("burst_gap2", start_at(2) - start_at(1), FLEN + 1);
    chk("burst_cpu_en", {31'd0, cpu_en}, 32'd1);
    chk("burst_busy", {31'd0, busy}, 32'd0);

    // wrap-around, paced by cpu_en
    f0 = frames_seen;
    for (int i = 0; i < 10; i++) begin
      wait_cpu_en(300);
      send(i[7:0], 1, 1'b1, n);
    end
    wait_idle(1000);
    chk("wrap_frames", frames_seen - f0, 32'd10);
    chk("wrap_count", {29'd0, fifo_count}, 32'd0);
    chk("wrap_overflow", {31'd0, overflow}, 32'd0);

    // overflow: TX busy with 0x77, six edges ignoring cpu_en, last two dropped
    send(8'h77, 1, 1'b1, n);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      send(8'h80 + i[7:0], 1, (i < 4), n);
    end
    chk("ovf_count_full", {29'd0, fifo_count}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_cpu_en", {31'd0, cpu_en}, 32'd0);
    wait_idle(600);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_drain_count", {29'd0, fifo_count}, 32'd0);
    chk("ovf_drain_cpu_en", {31'd0, cpu_en}, 32'd1);

    // reset during DATA bit 3, with stdout_en held high across reset release
    send(8'hA5, 1, 1'b1, n);
    send(8'h3C, 1, 1'b1, n2);
    s = n + 2;
    while (cyc < s + 4 * CPB + 1) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_tx_bit3", {31'd0, tx}, 32'd0);
    chk("pre_rst_count", {29'd0, fifo_count}, 32'd1);
    reset     = 1'b1;
    stdout    = 8'hEE;
    stdout_en = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_count", {29'd0, fifo_count}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    f0 = frames_seen;
    repeat (5) @(posedge clk);
    #1 stdout_en = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("rst_held_en_frames", frames_seen - f0, 32'd0);
    chk("rst_held_en_count", {29'd0, fifo_count}, 32'd0);
    send(8'h5A, 1, 1'b1, n);
    wait_idle(200);
    chk("post_rst_frames", frames_seen - f0, 32'd1);
    chk("exp_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stdout_uart_tx.md
STDOUT_UART_TX -- requirements
Module: stdout_uart_tx

Parameters
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, giving the clock cycles per UART bit; legal values are 2 or more.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of bytes buffered; it is a power of two, 4 or more.

Interface
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stdout  in  8  output byte from the processor.
REQ-006 stdout_en  in  1  byte-valid from the processor; high for 1 or more consecutive cycles per byte.
REQ-007 tx  out  1  UART serial line, 8N1, idle high.
REQ-008 cpu_en  out  1  processor enable; low stalls the processor.
REQ-009 busy  out  1  high while the FIFO is non-empty or a frame is in flight.
REQ-010 overflow  out  1  sticky flag; a byte was dropped.
REQ-011 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued.

Function
REQ-012 Capture SHALL occur on the rising edge of stdout_en only: stdout_en sampled 1 when the registered previous value was 0; a multi-cycle high pulse SHALL push exactly one byte.
REQ-013 On capture, stdout SHALL be written into the FIFO at that same clock edge, provided the FIFO is not full.
REQ-014 Capture with the FIFO full SHALL drop the byte and set overflow=1; overflow SHALL clear only on reset.
REQ-015 The FIFO SHALL be a circular buffer; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 A simultaneous push and pop SHALL both succeed and leave fifo_count unchanged; a push while full and popping in the same cycle SHALL succeed.
REQ-017 cpu_en SHALL be 0 whenever fifo_count >= FIFO_DEPTH-1, and 1 otherwise; this is a registered output, updated the cycle after the count changes.
REQ-018 The TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 In IDLE, with the FIFO non-empty, the FSM SHALL pop the head byte into a shift register and enter START at that same edge.
REQ-020 In START, tx SHALL be 0 for CLKS_PER_BIT cycles; the FSM then enters DATA.
REQ-021 In DATA, tx SHALL drive 8 bits LSB first, CLKS_PER_BIT cycles each, counted by a 3-bit index; after bit 7 the FSM enters STOP.
REQ-022 In STOP, tx SHALL be 1 for CLKS_PER_BIT cycles; the FSM then returns to IDLE.
REQ-023 In IDLE, tx SHALL be 1.
REQ-024 Back-to-back frames SHALL have no idle gap: if the FIFO is non-empty at the end of STOP, the next pop SHALL occur on the first IDLE cycle (one-cycle IDLE dwell).
REQ-025 tx SHALL be registered, with no combinational path from any input to tx.
REQ-026 Latency: if the capture edge is cycle N and the FSM is IDLE, tx SHALL go low starting at cycle N+2.
REQ-027 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and reset to 0 at each bit boundary.

Reset
REQ-028 While reset=1, at each clock edge the block SHALL set: tx=1, cpu_en=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, pointers=0, edge-detect register=0.
REQ-029 A reset mid-frame SHALL abort the frame; tx SHALL be 1 from the following edge, and queued bytes SHALL be discarded.
REQ-030 A stdout_en already high when reset deasserts SHALL NOT be captured until it goes low and high again.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single byte: stdout=0x48 with stdout_en high 2 cycles -> tx low at N+2, then bits 0,0,0,1,0,0,1,0 at 4 cycles each, then stop high; 40 cycles from start bit to IDLE; one frame only.
REQ-032 Burst: 3 bytes 0x41,0x42,0x43 spaced 3 cycles apart -> cpu_en=0 once count reaches 3; three contiguous frames with a 1-cycle idle between stop and start; then cpu_en=1, busy=0.
REQ-033 Overflow: 6 rising edges with cpu_en ignored and TX occupied -> exactly 4 bytes are transmitted in order, overflow=1 and it remains set.
REQ-034 Wrap-around: 10 bytes 0x00..0x09 paced by cpu_en -> all 10 bytes are serialized in order, and fifo_count returns to 0.
REQ-035 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 at the next edge, fifo_count=0, and the next byte after reset is transmitted intact.
REQ-036 Held enable: stdout_en held high 20 cycles -> exactly one byte is captured.
